// File: rtl/ecc_pkg.sv
// ecc_pkg: shared Hamming(15,11) constants, bit positions and FSM states for the ECC encoder/decoder
// Contents: N/K/R code sizes, data and parity position tables, state_t enum,
//           cover_mask() giving the codeword positions checked by parity bit j.
package ecc_pkg;
    localparam int N = 15;
    localparam int K = 11;
    localparam int R = 4;
    localparam int DATA_POS [K] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
    localparam int PAR_POS [R] = '{0, 1, 3, 7};
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    // Parity j covers every codeword index whose 1-based position has bit j set
    function automatic logic [0:N-1] cover_mask(input int j);
        logic [0:N-1] m;
        for (int k = 0; k < N; k++) m[k] = ((k + 1) & (1 << j)) != 0;
        return m;
    endfunction
endpackage

// File: rtl/hamming15_11_enc.sv
// hamming15_11_enc: combinational Hamming(15,11) encoder, c[0] first
// Ports: data [0:10] in (d[0] first), cw [0:14] out (codeword, c[0] first).
module hamming15_11_enc
    import ecc_pkg::*;
(
    input  logic [0:K-1] data,
    output logic [0:N-1] cw
);
    logic [0:N-1] m;
    // Parity slots are still zero in m, so masking m yields exactly the covered data bits
    always_comb begin
        m = '0;
        for (int i = 0; i < K; i++) m[DATA_POS[i]] = data[i];
        cw = m;
        for (int j = 0; j < R; j++) cw[PAR_POS[j]] = ^(m & cover_mask(j));
    end
endmodule

// File: rtl/ecc_encoder_serial.sv
// ecc_encoder_serial: Hamming(15,11) encoder that holds the codeword and streams it bit-serially
// Ports: clk, rst_n (sync, active-low), enable (freeze when 0);
//        in_data/in_valid/in_ready: data word handshake;
//        cw_out/cw_valid: registered codeword and its in-flight flag;
//        ser_bit/ser_valid/ser_ready/ser_last: serial stream with backpressure;
//        done: pulse after c[14] accepted; word_cnt: saturating completed-word count.
module ecc_encoder_serial
    import ecc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [0:K-1]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:N-1]     cw_out,
    output logic             cw_valid,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt
);
    state_t       state;
    logic [3:0]   idx;
    logic [0:N-1] cw_next;

    hamming15_11_enc u_enc (
        .data (in_data),
        .cw   (cw_next)
    );

    // DONE always falls back to IDLE, independent of enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cw_out   <= '0;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (enable && in_valid) begin
                    cw_out <= cw_next;
                    idx    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: if (enable && ser_ready) begin
                    if (idx == 4'd14) state <= DONE;
                    else idx <= idx + 4'd1;
                end
                DONE: begin
                    state <= IDLE;
                    if (!(&word_cnt)) word_cnt <= word_cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window
    assign in_ready  = rst_n && state == IDLE;
    assign cw_valid  = state == SHIFT;
    assign ser_valid = state == SHIFT;
    assign ser_bit   = state == SHIFT ? cw_out[idx] : 1'b0;
    assign ser_last  = state == SHIFT && idx == 4'd14;
    assign done      = state == DONE;
endmodule

// File: tb/tb_ecc_encoder_serial.sv
// tb_ecc_encoder_serial: directed self-checking bench for ecc_encoder_serial
module tb_ecc_encoder_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [0:10] in_data = '0;
    logic        in_valid = 1'b0;
    logic        ser_ready = 1'b1;
    logic        in_ready, cw_valid, ser_bit, ser_valid, ser_last, done;
    logic [0:14] cw_out;
    logic [7:0]  word_cnt;
    logic        s_in_ready, s_cw_valid, s_ser_bit, s_ser_valid, s_ser_last, s_done;
    logic [0:14] s_cw_out;
    logic [1:0]  s_word_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    int          exp_small = 0;

    always #5 clk = ~clk;

    ecc_encoder_serial #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cw_out(cw_out), .cw_valid(cw_valid), .ser_bit(ser_bit),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last), .done(done),
        .word_cnt(word_cnt)
    );

    ecc_encoder_serial #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(s_in_ready), .cw_out(s_cw_out), .cw_valid(s_cw_valid), .ser_bit(s_ser_bit),
        .ser_valid(s_ser_valid), .ser_ready(ser_ready), .ser_last(s_ser_last), .done(s_done),
        .word_cnt(s_word_cnt)
    );

    function automatic logic [0:14] ref_enc(input logic [0:10] d);
        logic [0:14] c;
        c = '0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        for (int i = 0; i < 7; i++) c[8+i] = d[4+i];
        c[0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
        c[1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
        c[3] = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
        c[7] = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
        return c;
    endfunction

    function automatic logic [3:0] syndrome(input logic [0:14] c);
        return {c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14],
                c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14],
                c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14],
                c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14]};
    endfunction

    function automatic logic [0:10] extract(input logic [0:14] c);
        return {c[2], c[4], c[5], c[6], c[8], c[9], c[10], c[11], c[12], c[13], c[14]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [0:10] d, input logic [0:14] exp, input bit stall);
        logic [0:14] rx;
        logic        prev_bit;
        bit          held;
        int          cnt, cyc, off;
        rx = '0; prev_bit = 1'b0; held = 0; cnt = 0; cyc = 0; off = 0;
        in_data = d;
        in_valid = 1'b1;
        while (!in_ready && cyc < 50) begin step(); cyc++; end
        step();
        in_valid = 1'b0;
        in_data = ~d;
        n_cmp++;
        if (cw_out !== exp) $display("FAIL cw_out: got %h expected %h", cw_out, exp);
        if (cw_out !== exp) n_err++;
        n_cmp++;
        if (cw_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL shift_flags: cw_valid=%b in_ready=%b expected 1/0", cw_valid, in_ready);
        end
        cyc = 0;
        while (cnt < 15 && cyc < 200) begin
            ser_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall && cnt == 7 && off < 3) begin enable = 1'b0; off++; end
            else enable = 1'b1;
            if (held) begin
                n_cmp++;
                if (ser_valid !== 1'b1 || ser_bit !== prev_bit) begin
                    n_err++;
                    $display("FAIL stall_hold: bit %0d got v=%b b=%b expected v=1 b=%b", cnt, ser_valid, ser_bit, prev_bit);
                end
            end
            n_cmp++;
            if (ser_valid !== 1'b1 || ser_last !== (cnt == 14)) begin
                n_err++;
                $display("FAIL ser_flags: bit %0d got v=%b last=%b expected v=1 last=%b", cnt, ser_valid, ser_last, cnt == 14);
            end
            prev_bit = ser_bit;
            if (ser_ready && enable) begin rx[cnt] = ser_bit; cnt++; held = 0; end
            else held = 1;
            step();
            cyc++;
        end
        enable = 1'b1;
        ser_ready = 1'b1;
        n_cmp++;
        if (cnt != 15) begin n_err++; $display("FAIL timeout: got %0d bits expected 15", cnt); end
        n_cmp++;
        if (rx !== exp) begin n_err++; $display("FAIL serial_stream: got %h expected %h", rx, exp); end
        n_cmp++;
        if (syndrome(rx) !== 4'd0 || extract(rx) !== d) begin
            n_err++;
            $display("FAIL decode: syndrome %h data %h expected 0 / %h", syndrome(rx), extract(rx), d);
        end
        n_cmp++;
        if (done !== 1'b1 || ser_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_state: done=%b ser_valid=%b in_ready=%b expected 1/0/0", done, ser_valid, in_ready);
        end
        step();
        exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
        exp_small = exp_small < 3 ? exp_small + 1 : 3;
        n_cmp++;
        if (done !== 1'b0 || in_ready !== 1'b1 || cw_valid !== 1'b0 || cw_out !== exp) begin
            n_err++;
            $display("FAIL after_done: done=%b in_ready=%b cw_valid=%b cw=%h expected 0/1/0/%h", done, in_ready, cw_valid, cw_out, exp);
        end
        n_cmp++;
        if (word_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL word_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
        n_cmp++;
        if (s_word_cnt !== 2'(exp_small)) begin n_err++; $display("FAIL word_cnt_sat: got %0d expected %0d", s_word_cnt, exp_small); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; ser_ready = 1'b1;
        step(); step();
        n_cmp++;
        if (in_ready !== 1'b0 || cw_out !== 15'h0 || cw_valid !== 1'b0 || ser_bit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: in_ready=%b cw=%h cw_valid=%b ser_bit=%b expected 0/0/0/0", in_ready, cw_out, cw_valid, ser_bit);
        end
        n_cmp++;
        if (ser_valid !== 1'b0 || ser_last !== 1'b0 || done !== 1'b0 || word_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_b: ser_valid=%b ser_last=%b done=%b cnt=%0d expected 0/0/0/0", ser_valid, ser_last, done, word_cnt);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release: in_ready=%b expected 1", in_ready); end
        exp_cnt = 0; exp_small = 0;
    endtask

    task automatic test_zero();
        run_word(11'h000, 15'h0000, 1'b0);
    endtask

    task automatic test_ones();
        run_word(11'h7FF, 15'h7FFF, 1'b0);
    endtask

    task automatic test_d0();
        run_word(11'b100_0000_0000, 15'h7000, 1'b0);
    endtask

    task automatic test_enable_idle();
        enable = 1'b0;
        in_data = 11'h2AB;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (in_ready !== 1'b1 || ser_valid !== 1'b0 || cw_valid !== 1'b0 || cw_out !== 15'h7000) begin
                n_err++;
                $display("FAIL enable_idle: in_ready=%b ser_valid=%b cw_valid=%b cw=%h expected 1/0/0/7000", in_ready, ser_valid, cw_valid, cw_out);
            end
        end
        in_valid = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_stall();
        logic [0:10] words [3] = '{11'h5A3, 11'h2C7, 11'h001};
        for (int i = 0; i < 3; i++) run_word(words[i], ref_enc(words[i]), 1'b1);
    endtask

    task automatic test_reset_mid();
        in_data = 11'h3A5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        ser_ready = 1'b1;
        repeat (7) step();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_hold: in_ready=%b ser_valid=%b expected 0/0", in_ready, ser_valid);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || ser_valid !== 1'b0 || word_cnt !== 8'd0 || s_word_cnt !== 2'd0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: in_ready=%b ser_valid=%b cnt=%0d small=%0d done=%b expected 1/0/0/0/0", in_ready, ser_valid, word_cnt, s_word_cnt, done);
        end
        exp_cnt = 0; exp_small = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (done !== 1'b0) begin n_err++; $display("FAIL reset_mid_done: cycle %0d done=%b expected 0", i, done); end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) run_word(11'(i * 37), ref_enc(11'(i * 37)), 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_d0();
        test_enable_idle();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ecc_encoder_serial.md
Name: ecc_encoder_serial

Overview:
- Hamming(15,11) encoder for the PUF ECC path; it is the transmit-side counterpart of the existing syndrome decoder.
- Accepts an 11-bit data word over a valid/ready handshake and computes the 15-bit codeword in one cycle.
- Holds the codeword in parallel form and streams it bit-serially, with backpressure, to helper-data storage.
- Codeword bit ordering and parity equations match the decoder exactly, so encoder output decodes with zero syndrome.

Parameters:
- CNT_W, 8, width of the saturating count of encoded words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  1 = block advances; 0 = all state frozen, no handshakes complete.
- in_data  input  [0:10]  data word, d[0] first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- cw_out  output  [0:14]  registered codeword, c[0] first.
- cw_valid  output  1  cw_out holds the word currently being serialized.
- ser_bit  output  1  current serial bit.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  sink accepts ser_bit.
- ser_last  output  1  ser_bit is c[14].
- done  output  1  one-cycle pulse after c[14] is accepted.
- word_cnt  output  [CNT_W-1:0]  number of completed words, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge) is synchronous and active-low. It overrides enable and aborts any word in flight. Reset values:
  - state=IDLE, in_ready=0 during reset and 1 in the first cycle after it.
  - cw_out=0, cw_valid=0, ser_bit=0, ser_valid=0, ser_last=0, done=0, word_cnt=0.
- Data mapping:
  - c[2]=d0, c[4]=d1, c[5]=d2, c[6]=d3.
  - c[8..14]=d4..d10.
- Parity (XOR):
  - c[0]=c2^c4^c6^c8^c10^c12^c14.
  - c[1]=c2^c5^c6^c9^c10^c13^c14.
  - c[3]=c4^c5^c6^c11^c12^c13^c14.
  - c[7]=c8^c9^c10^c11^c12^c13^c14.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, ser_valid=0, cw_valid=0.
  - On enable & in_valid: register the encoded word into cw_out, set idx=0, go to SHIFT.
  - Latency: the first serial bit is valid on the cycle after acceptance.
- SHIFT:
  - in_ready=0, cw_valid=1, ser_valid=1, ser_bit=cw_out[idx], ser_last=(idx==14).
  - On enable & ser_ready: if idx<14, idx+1; if idx==14, go to DONE.
  - ser_ready=0 holds idx, ser_bit and ser_valid stable.
- DONE:
  - done=1 for exactly one cycle; ser_valid=0, in_ready=0.
  - word_cnt increments unless it is already all-ones (saturates).
  - Unconditional return to IDLE, even if enable=0.
- Throughput: one word per 17 cycles minimum (1 accept + 15 shift + 1 done).
- enable=0 behaviour:
  - in_ready and ser_valid keep their state-derived values.
  - No transfer completes while enable=0, even if valid and ready are both high.
  - All registers hold, except the DONE to IDLE transition described above.
- in_data is ignored outside IDLE; in_valid held high is not consumed until the next IDLE.
- cw_out retains the last codeword after DONE until the next acceptance; only cw_valid deasserts.
- idx is a 4-bit counter that never exceeds 14.

Decomposition:
- Shared package ecc_pkg holds:
  - constants N=15, K=11, R=4;
  - localparams for the data-position list {2,4,5,6,8..14} and parity positions {0,1,3,7};
  - the FSM state enum.
- The decoder imports the same package.
- One combinational sub-module, hamming15_11_enc (in_data to codeword), instantiated here and reusable by the test bench as a reference model.

Test Plan:
- Reset then in_data=11'b000_0000_0000 -> cw_out=15'h0000; 15 serial zeros; ser_last on the 15th bit; done pulse; word_cnt=1.
- in_data=11'h7FF -> cw_out=15'h7FFF (all ones); serial stream of 15 ones.
- in_data=11'b100_0000_0000 (d0=1) -> cw_out=15'h7000 (c0,c1,c2 set); serial order 1,1,1,0 x12.
- Random ser_ready stalls plus enable=0 for 3 cycles mid-word:
  - bit sequence is unchanged; ser_bit and ser_valid are stable while stalled;
  - each codeword fed to the decoder yields syndrome 0 and the original data.
- rst_n=0 asserted at idx=7 -> next cycle IDLE, in_ready=1, ser_valid=0, word_cnt=0, no done pulse.
- CNT_W=2 with 5 words -> word_cnt sequence 1,2,3,3,3.
